// File: rtl/tb_cmd_arb_pkg.sv
// Purpose: shared types and constants for the round-robin command arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package tb_cmd_arb_pkg;

    // Width of the saturating timeout-completion counter.
    localparam int TMO_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/tb_cmd_arbiter_if.sv
// Purpose: request/command/completion bundle between requesters, arbiter and decoder.
// Latency: n/a (wires only).
// Backpressure: requesters hold i_req_valid until o_req_ack; no other stall signal.
// Ports: slave = arbiter side, master = requester/decoder side.
interface tb_cmd_arbiter_if
    import tb_cmd_arb_pkg::*;
#(
    parameter int NB_REQ    = 4,
    parameter int CMD_WIDTH = 8,
    parameter int ARG_WIDTH = 32,
    parameter int SRC_WIDTH = $clog2(NB_REQ)
) ();

    logic [NB_REQ-1:0]                  i_req_valid;
    logic [NB_REQ-1:0][CMD_WIDTH-1:0]   i_req_cmd;
    logic [NB_REQ-1:0][ARG_WIDTH-1:0]   i_req_arg;
    logic [NB_REQ-1:0]                  o_req_ack;
    logic [NB_REQ-1:0]                  o_req_err;
    logic                               o_cmd_valid;
    logic [CMD_WIDTH-1:0]               o_cmd;
    logic [ARG_WIDTH-1:0]               o_arg;
    logic [SRC_WIDTH-1:0]               o_cmd_src;
    logic                               i_cmd_done;
    logic                               o_busy;
    logic [TMO_COUNT_WIDTH-1:0]         o_tmo_count;

    modport slave (
        input  i_req_valid, i_req_cmd, i_req_arg, i_cmd_done,
        output o_req_ack, o_req_err, o_cmd_valid, o_cmd, o_arg, o_cmd_src,
               o_busy, o_tmo_count
    );

    modport master (
        output i_req_valid, i_req_cmd, i_req_arg, i_cmd_done,
        input  o_req_ack, o_req_err, o_cmd_valid, o_cmd, o_arg, o_cmd_src,
               o_busy, o_tmo_count
    );

endinterface

// File: rtl/tb_cmd_arbiter_rr_pick.sv
// Purpose: combinational round-robin selector; first set request after ptr, with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; any_vld=0 when no request is set.
// Ports: req (request vector), ptr (last winner), winner (index), any_vld.
module rr_pick #(
    parameter int NB_REQ    = 4,
    parameter int SRC_WIDTH = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0]    req,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic [SRC_WIDTH-1:0] winner,
    output logic                 any_vld
);

    int idx;

    // Offsets run 1..NB_REQ so the previous winner is searched last.
    always_comb begin
        winner  = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NB_REQ; i++) begin
            idx = (int'(ptr) + i) % NB_REQ;
            if (!any_vld && req[idx]) begin
                any_vld = 1'b1;
                winner  = SRC_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/tb_cmd_arbiter.sv
// Purpose: round-robin arbiter issuing one command at a time to a shared decoder path.
// Latency: strobe 1 cycle after grant; ack 1 cycle after done, or TIMEOUT_CYCLES+2 after grant.
// Backpressure: one command in flight; other requesters hold valid until their own ack.
// Ports: clk, rst_n (sync, active-low), bus (slave side of tb_cmd_arbiter_if).
module tb_cmd_arbiter
    import tb_cmd_arb_pkg::*;
#(
    parameter int NB_REQ         = 4,
    parameter int CMD_WIDTH      = 8,
    parameter int ARG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SRC_WIDTH      = $clog2(NB_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    tb_cmd_arbiter_if.slave  bus
);

    localparam int                  TIMER_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]  TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                  state_q, state_d;
    logic [SRC_WIDTH-1:0]        ptr_q;
    logic [SRC_WIDTH-1:0]        src_q;
    logic [CMD_WIDTH-1:0]        cmd_q;
    logic [ARG_WIDTH-1:0]        arg_q;
    logic [TIMER_W-1:0]          timer_q;
    logic                        err_q;
    logic [TMO_COUNT_WIDTH-1:0]  tmo_q;

    logic [SRC_WIDTH-1:0]        win;
    logic                        any_req;

    rr_pick #(
        .NB_REQ    (NB_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .req     (bus.i_req_valid),
        .ptr     (ptr_q),
        .winner  (win),
        .any_vld (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus state-decoded outputs; no input reaches an output here.
    always_comb begin
        state_d         = state_q;
        bus.o_cmd_valid = 1'b0;
        bus.o_req_ack   = '0;
        bus.o_req_err   = '0;
        bus.o_busy      = (state_q != IDLE);
        case (state_q)
            IDLE:  if (any_req) state_d = ISSUE;
            ISSUE: begin
                bus.o_cmd_valid = 1'b1;
                state_d         = WAIT;
            end
            WAIT:  if (bus.i_cmd_done || timer_q == TMO_LAST) state_d = RESP;
            RESP: begin
                bus.o_req_ack[src_q] = 1'b1;
                bus.o_req_err[src_q] = err_q;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= SRC_WIDTH'(NB_REQ - 1);
            src_q   <= '0;
            cmd_q   <= '0;
            arg_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    src_q <= win;
                    cmd_q <= bus.i_req_cmd[win];
                    arg_q <= bus.i_req_arg[win];
                    err_q <= 1'b0;
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    // Done has priority over a timeout landing in the same cycle.
                    if (bus.i_cmd_done) begin
                        err_q <= 1'b0;
                    end else if (timer_q == TMO_LAST) begin
                        err_q <= 1'b1;
                        if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: ptr_q <= src_q;
                default: ;
            endcase
        end
    end

    assign bus.o_cmd       = cmd_q;
    assign bus.o_arg       = arg_q;
    assign bus.o_cmd_src   = src_q;
    assign bus.o_tmo_count = tmo_q;

endmodule

// File: tb/tb_tb_cmd_arbiter.sv
// Purpose: directed self-checking bench for tb_cmd_arbiter (4 requesters, timeout 16).
// Latency: n/a.
// Backpressure: requester model drops valid on ack when its drop_mask bit is set.
module tb_tb_cmd_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tb_cmd_arbiter_if #(.NB_REQ(4), .CMD_WIDTH(8), .ARG_WIDTH(32), .SRC_WIDTH(2)) ifc ();

    tb_cmd_arbiter #(
        .NB_REQ(4), .CMD_WIDTH(8), .ARG_WIDTH(32), .TIMEOUT_CYCLES(16), .SRC_WIDTH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         cyc;
    int         last_strobe;
    int         done_delay;
    int         n_strobes;
    logic [3:0] drop_mask;
    logic [7:0] strobe_cmd, ack_cmd;
    logic [31:0] strobe_arg, ack_arg;
    int         grant_q[$];
    int         ack_cyc_q[$];
    logic [3:0] ack_word_q[$];
    logic [3:0] err_word_q[$];
    int         stray_err;

    task automatic clear_log();
        cyc = 0; last_strobe = -100; n_strobes = 0; stray_err = 0;
        grant_q.delete(); ack_cyc_q.delete(); ack_word_q.delete(); err_word_q.delete();
    endtask

    // One clock: sample outputs 1ns after the edge, then drive the next inputs.
    task automatic step();
        @(posedge clk); #1; cyc++;
        if (ifc.o_cmd_valid) begin
            grant_q.push_back(int'(ifc.o_cmd_src));
            last_strobe = cyc; n_strobes++;
            strobe_cmd = ifc.o_cmd; strobe_arg = ifc.o_arg;
        end
        if (ifc.o_req_ack != 4'b0) begin
            ack_cyc_q.push_back(cyc);
            ack_word_q.push_back(ifc.o_req_ack);
            err_word_q.push_back(ifc.o_req_err);
            ack_cmd = ifc.o_cmd; ack_arg = ifc.o_arg;
            for (int i = 0; i < 4; i++)
                if (ifc.o_req_ack[i] && drop_mask[i]) ifc.i_req_valid[i] = 1'b0;
        end else if (ifc.o_req_err != 4'b0) begin
            stray_err++;
        end
        if (done_delay >= 0) ifc.i_cmd_done = (cyc == last_strobe + done_delay);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ifc.i_req_valid = 4'b0; ifc.i_cmd_done = 1'b0;
        done_delay = -1; drop_mask = 4'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.i_req_cmd[i] = 8'h0; ifc.i_req_arg[i] = 32'h0;
        end
        clear_log();
        step(); step();
        n_checks++; if (ifc.o_req_ack !== 4'b0) begin n_errors++; $display("FAIL reset_ack got %b want 0000", ifc.o_req_ack); end
        n_checks++; if (ifc.o_req_err !== 4'b0) begin n_errors++; $display("FAIL reset_err got %b want 0000", ifc.o_req_err); end
        n_checks++; if (ifc.o_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_valid got %b want 0", ifc.o_cmd_valid); end
        n_checks++; if (ifc.o_cmd !== 8'h0) begin n_errors++; $display("FAIL reset_cmd got %h want 00", ifc.o_cmd); end
        n_checks++; if (ifc.o_arg !== 32'h0) begin n_errors++; $display("FAIL reset_arg got %h want 0", ifc.o_arg); end
        n_checks++; if (ifc.o_cmd_src !== 2'd0) begin n_errors++; $display("FAIL reset_src got %0d want 0", ifc.o_cmd_src); end
        n_checks++; if (ifc.o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", ifc.o_busy); end
        n_checks++; if (ifc.o_tmo_count !== 16'd0) begin n_errors++; $display("FAIL reset_tmo got %0d want 0", ifc.o_tmo_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        clear_log();
        done_delay = 3; drop_mask = 4'b0001;
        ifc.i_req_cmd[0] = 8'h12; ifc.i_req_arg[0] = 32'hDEADBEEF; ifc.i_req_valid[0] = 1'b1;
        step();
        // Post-grant changes must not reach the latched command.
        ifc.i_req_cmd[0] = 8'h34; ifc.i_req_arg[0] = 32'h0;
        repeat (9) step();
        n_checks++; if (n_strobes !== 1) begin n_errors++; $display("FAIL single_strobes got %0d want 1", n_strobes); end
        n_checks++; if (grant_q.size() < 1 || grant_q[0] !== 0) begin n_errors++; $display("FAIL single_src got %0d grants want src 0", grant_q.size()); end
        n_checks++; if (strobe_cmd !== 8'h12) begin n_errors++; $display("FAIL single_cmd got %h want 12", strobe_cmd); end
        n_checks++; if (strobe_arg !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_arg got %h want deadbeef", strobe_arg); end
        n_checks++; if (ack_word_q.size() !== 1) begin n_errors++; $display("FAIL single_ack_count got %0d want 1", ack_word_q.size()); end
        else begin
            n_checks++; if (ack_word_q[0] !== 4'b0001) begin n_errors++; $display("FAIL single_ack got %b want 0001", ack_word_q[0]); end
            n_checks++; if (err_word_q[0] !== 4'b0000) begin n_errors++; $display("FAIL single_err got %b want 0000", err_word_q[0]); end
            n_checks++; if (ack_cyc_q[0] !== 5) begin n_errors++; $display("FAIL single_ack_cycle got %0d want 5", ack_cyc_q[0]); end
            n_checks++; if (ack_cmd !== 8'h12 || ack_arg !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_latch got %h/%h want 12/deadbeef", ack_cmd, ack_arg); end
        end
        n_checks++; if (ifc.o_busy !== 1'b0) begin n_errors++; $display("FAIL single_idle got busy %b want 0", ifc.o_busy); end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; ifc.i_req_valid = 4'b0; done_delay = -1; ifc.i_cmd_done = 1'b0;
        step(); step();
        rst_n = 1'b1;
        clear_log();
        done_delay = 1; drop_mask = 4'b1111; ifc.i_req_valid = 4'b1111;
        repeat (16) step();
        n_checks++; if (grant_q.size() !== 4) begin n_errors++; $display("FAIL rr_grants got %0d want 4", grant_q.size()); end
        else begin
            n_checks++; if (grant_q[0] !== 0 || grant_q[1] !== 1 || grant_q[2] !== 2 || grant_q[3] !== 3) begin
                n_errors++; $display("FAIL rr_order got %0d%0d%0d%0d want 0123", grant_q[0], grant_q[1], grant_q[2], grant_q[3]); end
        end
        n_checks++; if (ack_cyc_q.size() !== 4 || ack_cyc_q[ack_cyc_q.size()-1] !== 15) begin n_errors++; $display("FAIL rr_last_ack got %0d acks want 4, last at 15", ack_cyc_q.size()); end
        n_checks++; if (ifc.o_busy !== 1'b0) begin n_errors++; $display("FAIL rr_total got busy %b at cycle 16 want 0", ifc.o_busy); end
    endtask

    task automatic test_alternation();
        clear_log();
        done_delay = 1; drop_mask = 4'b0000; ifc.i_req_valid = 4'b0101;
        repeat (16) step();
        ifc.i_req_valid = 4'b0000;
        n_checks++; if (grant_q.size() !== 4) begin n_errors++; $display("FAIL alt_grants got %0d want 4", grant_q.size()); end
        else begin
            n_checks++; if (grant_q[0] !== 0 || grant_q[1] !== 2 || grant_q[2] !== 0 || grant_q[3] !== 2) begin
                n_errors++; $display("FAIL alt_order got %0d%0d%0d%0d want 0202", grant_q[0], grant_q[1], grant_q[2], grant_q[3]); end
        end
    endtask

    task automatic test_timeout();
        clear_log();
        done_delay = -1; ifc.i_cmd_done = 1'b0; drop_mask = 4'b0010; ifc.i_req_valid[1] = 1'b1;
        repeat (22) step();
        n_checks++; if (ack_word_q.size() !== 1) begin n_errors++; $display("FAIL tmo_ack_count got %0d want 1", ack_word_q.size()); end
        else begin
            n_checks++; if (ack_cyc_q[0] !== 18) begin n_errors++; $display("FAIL tmo_ack_cycle got %0d want 18", ack_cyc_q[0]); end
            n_checks++; if (ack_word_q[0] !== 4'b0010 || err_word_q[0] !== 4'b0010) begin n_errors++; $display("FAIL tmo_ack_err got %b/%b want 0010/0010", ack_word_q[0], err_word_q[0]); end
        end
        n_checks++; if (ifc.o_tmo_count !== 16'd1) begin n_errors++; $display("FAIL tmo_count got %0d want 1", ifc.o_tmo_count); end
        n_checks++; if (stray_err !== 0) begin n_errors++; $display("FAIL tmo_stray_err got %0d want 0", stray_err); end
    endtask

    task automatic test_done_at_threshold();
        clear_log();
        done_delay = 16; drop_mask = 4'b0001; ifc.i_req_valid[0] = 1'b1;
        repeat (22) step();
        n_checks++; if (ack_word_q.size() !== 1) begin n_errors++; $display("FAIL thr_ack_count got %0d want 1", ack_word_q.size()); end
        else begin
            n_checks++; if (ack_cyc_q[0] !== 18) begin n_errors++; $display("FAIL thr_ack_cycle got %0d want 18", ack_cyc_q[0]); end
            n_checks++; if (ack_word_q[0] !== 4'b0001 || err_word_q[0] !== 4'b0000) begin n_errors++; $display("FAIL thr_ack_err got %b/%b want 0001/0000", ack_word_q[0], err_word_q[0]); end
        end
        n_checks++; if (ifc.o_tmo_count !== 16'd1) begin n_errors++; $display("FAIL thr_tmo_count got %0d want 1", ifc.o_tmo_count); end
    endtask

    task automatic test_reset_in_wait();
        clear_log();
        done_delay = -1; ifc.i_cmd_done = 1'b0; drop_mask = 4'b1000; ifc.i_req_valid[3] = 1'b1;
        repeat (4) step();
        n_checks++; if (ifc.o_busy !== 1'b1) begin n_errors++; $display("FAIL rst_wait_busy got %b want 1", ifc.o_busy); end
        rst_n = 1'b0;
        step();
        n_checks++; if ({ifc.o_req_ack, ifc.o_req_err, ifc.o_cmd_valid, ifc.o_busy, ifc.o_cmd_src} !== 12'h0) begin
            n_errors++; $display("FAIL rst_wait_ctl got ack %b err %b vld %b busy %b src %0d want all 0",
                ifc.o_req_ack, ifc.o_req_err, ifc.o_cmd_valid, ifc.o_busy, ifc.o_cmd_src); end
        n_checks++; if (ifc.o_cmd !== 8'h0 || ifc.o_arg !== 32'h0 || ifc.o_tmo_count !== 16'd0) begin
            n_errors++; $display("FAIL rst_wait_data got %h/%h/%0d want 0/0/0", ifc.o_cmd, ifc.o_arg, ifc.o_tmo_count); end
        step();
        n_checks++; if (ack_word_q.size() !== 0) begin n_errors++; $display("FAIL rst_wait_no_ack got %0d acks want 0", ack_word_q.size()); end
        clear_log();
        done_delay = 1; drop_mask = 4'b1001; ifc.i_req_valid = 4'b1001; rst_n = 1'b1;
        repeat (8) step();
        n_checks++; if (grant_q.size() !== 2 || grant_q[0] !== 0 || grant_q[1] !== 3) begin
            n_errors++; $display("FAIL rst_then_order got %0d grants want 0 then 3", grant_q.size()); end
    endtask

    task automatic test_spurious_done();
        clear_log();
        done_delay = -1; drop_mask = 4'b0010; ifc.i_req_valid[1] = 1'b1;
        ifc.i_cmd_done = 1'b1;           // seen in IDLE
        step();                          // cycle 1: ISSUE, done still high
        step();                          // cycle 2: WAIT
        ifc.i_cmd_done = 1'b0;
        n_checks++; if (ifc.o_req_ack !== 4'b0 || ifc.o_busy !== 1'b1) begin n_errors++; $display("FAIL spur_wait got ack %b busy %b want 0000/1", ifc.o_req_ack, ifc.o_busy); end
        repeat (3) step();
        n_checks++; if (ack_word_q.size() !== 0) begin n_errors++; $display("FAIL spur_early_ack got %0d acks want 0", ack_word_q.size()); end
        ifc.i_cmd_done = 1'b1;
        step();
        ifc.i_cmd_done = 1'b0;
        step(); step();
        n_checks++; if (ack_word_q.size() !== 1) begin n_errors++; $display("FAIL spur_ack_count got %0d want 1", ack_word_q.size()); end
        else begin
            n_checks++; if (ack_cyc_q[0] !== 6 || ack_word_q[0] !== 4'b0010 || err_word_q[0] !== 4'b0000) begin
                n_errors++; $display("FAIL spur_ack got cycle %0d ack %b err %b want 6/0010/0000", ack_cyc_q[0], ack_word_q[0], err_word_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_alternation();
        test_timeout();
        test_done_at_threshold();
        test_reset_in_wait();
        test_spurious_done();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
